mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised modulo up/down counter, the next generation of the team's 4-bit free-running up-counter. Adds configurable width and modulus, direction control, count enable, synchronous clear and load, wrap-or-saturate mode, a cascade carry output, and wrap/overflow status. It serves as the general counting primitive for timers, decade chains and address generators in the sessional designs.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32.
- MAX, 2**WIDTH-1: highest count value, so the count range is 0..MAX. Must satisfy 1 <= MAX <= 2**WIDTH-1.

- clk  in  1  rising-edge clock; all state updates on the rising edge.
- res  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of din.
- din  in  WIDTH  load value.
- en  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down.
- sat  in  1  boundary mode: 0 wraps, 1 saturates.
- y  out  WIDTH  current count (registered).
- tc  out  1  terminal count and cascade carry (combinational).
- wrap  out  1  one-cycle pulse, registered.
- ovf  out  1  sticky overflow flag, registered.

## Operation
- Reset (res=0, asynchronous) drives y=0, wrap=0 and ovf=0 immediately. Release is synchronised by the integrator.
- Per-edge priority is clr > load > en > hold.
- clr=1: y<=0; ovf<=0; wrap<=0.
- load=1: y<=din if din<=MAX, otherwise y<=MAX and ovf<=1. wrap<=0.
- en=1, up=1:
  - y<MAX: y<=y+1.
  - y==MAX and sat=0: y<=0, wrap<=1, ovf<=1.
  - y==MAX and sat=1: y holds, ovf<=1, wrap<=0.
- en=1, up=0:
  - y>0: y<=y-1.
  - y==0 and sat=0: y<=MAX, wrap<=1, ovf<=1.
  - y==0 and sat=1: y holds, ovf<=1.
- en=0 with no clr or load: y holds, wrap<=0, ovf holds.
- wrap is high for exactly the one cycle following a wrapping edge. It is 0 on every other edge.
- ovf remains set until clr or reset.
- tc = en & ((up & y==MAX) | (~up & y==0)). It is asserted in both sat modes and is independent of clr and load. Cascading connects tc to the next stage's en.
- Arithmetic: compare against MAX before incrementing, so y never exceeds MAX. The WIDTH-bit add/subtract never relies on natural 2**WIDTH rollover unless MAX==2**WIDTH-1, and the result is the same in either case.
- up, sat and din may change on any cycle. They are sampled only at the edge.

## Timing
- Latency: y reflects any clr, load or count one edge after the control is sampled.
- wrap and ovf update on the same edge as y.
- tc is combinational from y, en and up, with zero latency. It is valid within the same cycle, so a downstream stage advances on the same edge the upstream wraps.
- Simultaneous clr+load+en: clr wins. load+en: load wins, and no count is applied to din.
- A direction change at a boundary takes effect at the next edge. For example, at y==MAX with up switched to 0 and en=1, y<=MAX-1 and there is no wrap.
- Reset asserted mid-count: outputs go to 0 asynchronously, without waiting for clk. The first count after release starts from 0.

## Structure
- Shared package `counter_pkg`:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - mode constants MODE_WRAP=1'b0 and MODE_SAT=1'b1;
  - a clog2 helper for integrators deriving WIDTH from MAX.
- One natural sub-module: `count_step`. It is combinational; given y, up, sat and MAX, it produces next_y, at_bound and wrap_evt. It is reused by later counter variants.
- Top level holds the y, wrap and ovf registers, priority muxing, load clamping and tc.

## Test plan
Benches run with WIDTH=4, MAX=9 (decade) unless stated.
- Reset then en=1, up=1, sat=0 for 12 edges -> y: 1..9, 0, 1, 2. wrap is high only the cycle after the 9->0 edge. tc=1 while y==9. ovf=1 after the wrap.
- up=0, sat=1, y=2, en=1 for 4 edges -> y: 1, 0, 0, 0. wrap stays 0. ovf is set on the first held edge. tc=1 while y==0.
- load=1, din=13 -> y=9 and ovf=1. Then clr=1 together with load=1, din=5 -> y=0, ovf=0.
- Two instances cascaded (tc0 -> en1), 100 clocks -> {y1,y0} counts 00..99 and then wraps to 00. Stage-1 wrap pulses once.
- Assert res=0 mid-cycle at y=7 -> y=0, wrap=0 and ovf=0 before the next clk edge. Counting after release starts at 1.
- WIDTH=8, MAX=255, up=0 from y=0, sat=0 -> y=255 with a wrap pulse. Then up=1 -> y=0 with a wrap pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode constants and width helper for the counter family
package counter_pkg;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    // Bits needed to count 0..v-1; use clog2(MAX+1) to size a counter for MAX.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned n;
        longint unsigned p;
        n = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            n++;
        end
        return n;
    endfunction
endpackage

// File: rtl/count_step.sv
// count_step: combinational next-value of a 0..MAX up/down counter
//   y        in  current count
//   up       in  direction (DIR_UP / DIR_DOWN)
//   sat      in  boundary mode (MODE_WRAP / MODE_SAT)
//   next_y   out value after one enabled step
//   at_bound out y sits at the boundary in the current direction
//   wrap_evt out this step wraps around the range
module count_step
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX = '1
) (
    input  logic [WIDTH-1:0] y,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] next_y,
    output logic             at_bound,
    output logic             wrap_evt
);
    logic             is_up;
    logic             is_sat;
    logic [WIDTH-1:0] wrap_y;
    logic [WIDTH-1:0] step_y;
    // Boundary is tested before stepping, so the add/subtract never has to roll over.
    always_comb begin
        is_up    = (up == DIR_UP);
        is_sat   = (sat == MODE_SAT);
        at_bound = is_up ? (y == MAX) : (y == '0);
        wrap_y   = is_up ? '0 : MAX;
        step_y   = is_up ? y + WIDTH'(1) : y - WIDTH'(1);
        next_y   = at_bound ? (is_sat ? y : wrap_y) : step_y;
        wrap_evt = at_bound & ~is_sat;
    end
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-(MAX+1) up/down counter with load, clear, saturate and cascade carry
//   clk  in  rising-edge clock
//   res  in  asynchronous active-low reset
//   clr  in  synchronous clear (highest priority)
//   load in  synchronous load of din, clamped to MAX
//   din  in  load value
//   en   in  count enable
//   up   in  direction, 1 = up
//   sat  in  boundary mode, 0 = wrap, 1 = saturate
//   y    out registered count
//   tc   out terminal count / cascade carry, combinational
//   wrap out one-cycle pulse after a wrapping edge
//   ovf  out sticky overflow, cleared by clr or reset
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX = '1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be 2..32");
    end
    if (MAX == '0) begin : g_bad_max
        $error("mod_updown_counter: MAX must be at least 1");
    end
    logic [WIDTH-1:0] next_y;
    logic             at_bound;
    logic             wrap_evt;
    logic             din_over;
    count_step #(.WIDTH(WIDTH), .MAX(MAX)) u_step (
        .y        (y),
        .up       (up),
        .sat      (sat),
        .next_y   (next_y),
        .at_bound (at_bound),
        .wrap_evt (wrap_evt)
    );
    assign din_over = (din > MAX);
    // Carry is gated only by en so a downstream stage advances on the same edge this one wraps.
    assign tc = en & at_bound;
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            y    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (clr) begin
            y    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            y    <= din_over ? MAX : din;
            wrap <= 1'b0;
            ovf  <= ovf | din_over;
        end else if (en) begin
            y    <= next_y;
            wrap <= wrap_evt;
            ovf  <= ovf | at_bound;
        end else begin
            wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: vector table, directed corners, cascade and random check against a model
module tb_mod_updown_counter;
    localparam int M = 9;
    typedef struct {
        logic       clr, load, en, up, sat;
        logic [3:0] din;
        logic [3:0] y;
        logic       w, o, tc;
    } vec_t;

    logic       clk = 0, res = 0, cres = 0;
    logic       clr = 0, load = 0, en = 0, up = 0, sat = 0;
    logic [3:0] din = 0;
    logic [3:0] y;
    logic       tc, wrap, ovf;
    logic [3:0] y0, y1;
    logic       tc0, tc1, w0, w1, o0, o1;
    logic       load8 = 0, en8 = 0, up8 = 0, sat8 = 0;
    logic [7:0] din8 = 0, y8;
    logic       tc8, w8, o8;
    int n_vec = 0, n_bad = 0;
    int my, mo, mw;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX(4'd9)) dut (
        .clk(clk), .res(res), .clr(clr), .load(load), .din(din), .en(en), .up(up), .sat(sat),
        .y(y), .tc(tc), .wrap(wrap), .ovf(ovf));
    mod_updown_counter #(.WIDTH(4), .MAX(4'd9)) c0 (
        .clk(clk), .res(cres), .clr(1'b0), .load(1'b0), .din(4'd0), .en(1'b1), .up(1'b1), .sat(1'b0),
        .y(y0), .tc(tc0), .wrap(w0), .ovf(o0));
    mod_updown_counter #(.WIDTH(4), .MAX(4'd9)) c1 (
        .clk(clk), .res(cres), .clr(1'b0), .load(1'b0), .din(4'd0), .en(tc0), .up(1'b1), .sat(1'b0),
        .y(y1), .tc(tc1), .wrap(w1), .ovf(o1));
    mod_updown_counter #(.WIDTH(8), .MAX(8'd255)) dut8 (
        .clk(clk), .res(res), .clr(1'b0), .load(load8), .din(din8), .en(en8), .up(up8), .sat(sat8),
        .y(y8), .tc(tc8), .wrap(w8), .ovf(o8));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, l, e, u, s, input int d, ey, ew, eo, etc);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.up = u; v.sat = s; v.din = 4'(d);
        v.y = 4'(ey); v.w = ew[0]; v.o = eo[0]; v.tc = etc[0];
        return v;
    endfunction

    // Reference: count lives in 0..M, stepping is modular arithmetic; a step off the end is an overflow.
    task automatic model(input logic c, l, e, u, s, input int d);
        int nxt;
        if (c) begin
            my = 0; mo = 0; mw = 0;
        end else if (l) begin
            if (d > M) begin my = M; mo = 1; end else my = d;
            mw = 0;
        end else if (e) begin
            nxt = (my + (u ? 1 : -1) + M + 1) % (M + 1);
            mw = 0;
            if ((u && my == M) || (!u && my == 0)) begin
                mo = 1;
                if (!s) begin my = nxt; mw = 1; end
            end else my = nxt;
        end else mw = 0;
    endtask

    task automatic drive(input logic c, l, e, u, s, input logic [3:0] d);
        @(negedge clk);
        clr = c; load = l; en = e; up = u; sat = s; din = d;
        #1;
    endtask

    initial begin
        #12;
        chk("reset_y", y, 0);
        chk("reset_wrap", wrap, 0);
        chk("reset_ovf", ovf, 0);
        @(negedge clk);
        res = 1;

        for (int i = 1; i <= 12; i++)
            tbl.push_back(mk(0, 0, 1, 1, 0, 0, i % 10, i == 10, i >= 10, i == 10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 2, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 13, 9, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 5, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 5, 5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 9, 9, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 9, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 9, 0, 1, 1));
        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].din);
            chk($sformatf("tbl%0d_tc", i), tc, tbl[i].tc);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_y", i), y, tbl[i].y);
            chk($sformatf("tbl%0d_wrap", i), wrap, tbl[i].w);
            chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].o);
        end

        drive(0, 1, 0, 1, 0, 4'd13);
        @(posedge clk);
        drive(0, 1, 0, 1, 0, 4'd7);
        @(posedge clk); #1;
        chk("pre_reset_y", y, 7);
        chk("pre_reset_ovf", ovf, 1);
        drive(0, 0, 0, 1, 0, 4'd0);
        #2 res = 0;
        #1;
        chk("async_reset_y", y, 0);
        chk("async_reset_wrap", wrap, 0);
        chk("async_reset_ovf", ovf, 0);
        @(negedge clk);
        res = 1;
        en = 1;
        @(posedge clk); #1;
        chk("after_release_y", y, 1);

        @(negedge clk);
        en = 0; load8 = 1; din8 = 0;
        @(negedge clk);
        load8 = 0; en8 = 1; up8 = 0; sat8 = 0;
        @(posedge clk); #1;
        chk("w8_down_y", y8, 255);
        chk("w8_down_wrap", w8, 1);
        @(negedge clk);
        up8 = 1;
        @(posedge clk); #1;
        chk("w8_up_y", y8, 0);
        chk("w8_up_wrap", w8, 1);
        @(negedge clk);
        en8 = 0;

        begin
            int wraps = 0;
            cres = 1;
            for (int i = 1; i <= 100; i++) begin
                @(posedge clk); #1;
                chk($sformatf("cascade%0d", i), int'(y1) * 10 + int'(y0), i % 100);
                wraps += int'(w1);
            end
            chk("cascade_wrap_pulses", wraps, 1);
            chk("cascade_final_wrap", w1, 1);
        end

        drive(1, 0, 0, 0, 0, 4'd0);
        @(posedge clk);
        my = 0; mo = 0; mw = 0;
        for (int i = 0; i < 300; i++) begin
            logic c, l, e, u, s;
            logic [3:0] d;
            c = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom);
            s = 1'($urandom);
            d = 4'($urandom_range(0, 15));
            drive(c, l, e, u, s, d);
            chk($sformatf("rnd%0d_tc", i), tc, int'(e && (u ? my == M : my == 0)));
            model(c, l, e, u, s, int'(d));
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_y", i), y, my);
            chk($sformatf("rnd%0d_wrap", i), wrap, mw);
            chk($sformatf("rnd%0d_ovf", i), ovf, mo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
